// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: ACE snoop responder that handles AC requests, runs the cache lookup, and returns CR, CD and a state update.
// Defining ACE_SNOOP_WRAP_EN makes CD return the critical word first and wrap around the line.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lkp_req_o,
  input  logic                 lkp_gnt_i,
  output logic [AddrWidth-1:0] lkp_addr_o,
  input  logic                 lkp_valid_i,
  input  logic                 lkp_hit_i,
  input  logic                 lkp_dirty_i,
  input  logic                 lkp_shared_i,
  input  logic [LineWidth-1:0] lkp_data_i,
  output logic                 upd_valid_o,
  output logic                 upd_invalidate_o,
  output logic                 upd_make_shared_o,
  output logic                 upd_clean_o,
  output logic [AddrWidth-1:0] upd_addr_o
);
  localparam int Beats = LineWidth / DataWidth;
  localparam int BW = Beats > 1 ? $clog2(Beats) : 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, SEND} state_t;
  state_t state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0] snoop_q;
  logic [2:0] prot_unused_q;
  logic [Beats-1:0][DataWidth-1:0] data_q;
  logic [4:0] cr_q, cr_d;
  logic inv_q, ms_q, cln_q, first_q, cr_done_q, cd_done_q;
  logic inv_d, ms_d, cln_d;
  logic [BW-1:0] beat_q, start, last_beat;
  logic ro, rs, ru, ci, cs, mi, sup, h, hd;
  logic cr_fire, cd_fire, cr_ok, cd_ok;
  assign ro  = snoop_q == 4'b0000;
  assign rs  = snoop_q == 4'b0001 || snoop_q == 4'b0010 || snoop_q == 4'b0011;
  assign ru  = snoop_q == 4'b0111;
  assign ci  = snoop_q == 4'b1001;
  assign cs  = snoop_q == 4'b1000;
  assign mi  = snoop_q == 4'b1101;
  assign sup = ro | rs | ru | ci | cs | mi;
  assign h   = lkp_hit_i & sup;
  assign hd  = h & lkp_dirty_i;
  // {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  assign cr_d  = {h & ~lkp_shared_i, h & (ro | rs | cs), hd & (rs | ru | ci | cs), ~sup,
                  (h & (ro | rs | ru)) | (hd & (ci | cs))};
  assign inv_d = h & (ru | ci | mi);
  assign ms_d  = h & rs;
  assign cln_d = hd & (rs | cs);
`ifdef ACE_SNOOP_WRAP_EN
  assign start = BW'((addr_q >> $clog2(DataWidth / 8)) % Beats);
`else
  assign start = '0;
`endif
  assign last_beat = start == '0 ? BW'(Beats - 1) : start - 1'b1;
  assign ac_ready_o        = state_q == IDLE && !rst_i;
  assign lkp_req_o         = state_q == LOOKUP;
  assign lkp_addr_o        = lkp_req_o ? addr_q & ~AddrWidth'(LineWidth / 8 - 1) : '0;
  assign cr_valid_o        = state_q == SEND && !cr_done_q;
  assign cr_resp_o         = cr_q;
  assign cd_valid_o        = state_q == SEND && cr_q[0] && !cd_done_q;
  assign cd_data_o         = data_q[beat_q];
  assign cd_last_o         = cd_valid_o && beat_q == last_beat;
  assign upd_valid_o       = first_q & (inv_q | ms_q | cln_q);
  assign upd_invalidate_o  = upd_valid_o & inv_q;
  assign upd_make_shared_o = upd_valid_o & ms_q;
  assign upd_clean_o       = upd_valid_o & cln_q;
  assign upd_addr_o        = upd_valid_o ? addr_q : '0;
  assign cr_fire = cr_valid_o & cr_ready_i;
  assign cd_fire = cd_valid_o & cd_ready_i;
  assign cr_ok   = cr_done_q | cr_fire;
  assign cd_ok   = ~cr_q[0] | cd_done_q | (cd_fire & cd_last_o);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ac_valid_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = lkp_gnt_i ? WAIT : LOOKUP;
      WAIT:    state_d = lkp_valid_i ? SEND : WAIT;
      SEND:    state_d = cr_ok && cd_ok ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q        <= '0;
      snoop_q       <= '0;
      prot_unused_q <= '0;
      data_q        <= '0;
      cr_q          <= '0;
      inv_q         <= 1'b0;
      ms_q          <= 1'b0;
      cln_q         <= 1'b0;
      first_q       <= 1'b0;
      cr_done_q     <= 1'b0;
      cd_done_q     <= 1'b0;
      beat_q        <= '0;
    end else begin
      first_q <= 1'b0;
      if (state_q == IDLE && ac_valid_i) begin
        addr_q        <= ac_addr_i;
        snoop_q       <= ac_snoop_i;
        prot_unused_q <= ac_prot_i;
      end
      if (state_q == WAIT && lkp_valid_i) begin
        data_q    <= lkp_data_i;
        cr_q      <= cr_d;
        inv_q     <= inv_d;
        ms_q      <= ms_d;
        cln_q     <= cln_d;
        first_q   <= 1'b1;
        cr_done_q <= 1'b0;
        cd_done_q <= 1'b0;
        beat_q    <= start;
      end
      if (cr_fire) cr_done_q <= 1'b1;
      if (cd_fire) begin
        beat_q <= beat_q == BW'(Beats - 1) ? '0 : beat_q + 1'b1;
        if (cd_last_o) cd_done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: bench that checks the snoop responder against a table-driven model of the snoop response rules.
module tb_ace_snoop_responder;
  localparam int AW = 64, DW = 64, LW = 128, BEATS = LW / DW;
  logic clk = 0, rst_i = 1;
  logic ac_valid_i = 0, cr_ready_i = 0, cd_ready_i = 0, lkp_gnt_i = 0;
  logic lkp_valid_i = 0, lkp_hit_i = 0, lkp_dirty_i = 0, lkp_shared_i = 0;
  logic [AW-1:0] ac_addr_i = '0;
  logic [3:0] ac_snoop_i = '0;
  logic [2:0] ac_prot_i = '0;
  logic [LW-1:0] lkp_data_i = '0;
  logic ac_ready_o, cr_valid_o, cd_valid_o, cd_last_o, lkp_req_o;
  logic upd_valid_o, upd_invalidate_o, upd_make_shared_o, upd_clean_o;
  logic [4:0] cr_resp_o;
  logic [DW-1:0] cd_data_o;
  logic [AW-1:0] lkp_addr_o, upd_addr_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lkp_req_o(lkp_req_o), .lkp_gnt_i(lkp_gnt_i), .lkp_addr_o(lkp_addr_o),
    .lkp_valid_i(lkp_valid_i), .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
    .lkp_shared_i(lkp_shared_i), .lkp_data_i(lkp_data_i),
    .upd_valid_o(upd_valid_o), .upd_invalidate_o(upd_invalidate_o),
    .upd_make_shared_o(upd_make_shared_o), .upd_clean_o(upd_clean_o), .upd_addr_o(upd_addr_o)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Response table: returns {invalidate, make_shared, clean, cr[4:0]}
  function automatic logic [7:0] model(input logic [3:0] s, input logic h, d, sh);
    logic [4:0] cr;
    logic inv, ms, cln;
    cr = '0; inv = 0; ms = 0; cln = 0;
    case (s)
      4'b0000: if (h) cr = {~sh, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: if (h) begin cr = {~sh, 1'b1, d, 1'b0, 1'b1}; ms = 1; cln = d; end
      4'b0111: if (h) begin cr = {~sh, 1'b0, d, 1'b0, 1'b1}; inv = 1; end
      4'b1001: if (h) begin cr = {~sh, 1'b0, d, 1'b0, d}; inv = 1; end
      4'b1000: if (h) begin cr = {~sh, 1'b1, d, 1'b0, d}; cln = d; end
      4'b1101: if (h) begin cr = {~sh, 4'b0}; inv = 1; end
      default: cr = 5'b00010;
    endcase
    return {inv, ms, cln, cr};
  endfunction
  task automatic issue_ac(input logic [AW-1:0] addr, input logic [3:0] s);
    chk("ac_ready_idle", ac_ready_o, 1);
    ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = s; ac_prot_i = 3'($urandom);
    @(negedge clk);
    ac_valid_i = 0; ac_addr_i = {$urandom, $urandom}; ac_snoop_i = 4'($urandom);
    chk("lkp_req", lkp_req_o, 1);
    chk("lkp_addr", lkp_addr_o, addr & ~AW'(LW / 8 - 1));
    chk("ac_ready_busy", ac_ready_o, 0);
  endtask
  task automatic grant(input int gd);
    for (int k = 0; k <= gd; k++) begin
      chk("lkp_req_hold", lkp_req_o, 1);
      lkp_gnt_i = (k == gd);
      @(negedge clk);
    end
    lkp_gnt_i = 0;
    chk("lkp_req_drop", lkp_req_o, 0);
  endtask
  task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] s, input logic h, d, sh,
                           input logic [LW-1:0] line, input int cr_mode, input int cd_mode, input int gd, input int vd);
    logic [7:0] e;
    int nb, st, n, beats, upd_n, idx;
    bit cr_done;
    e = model(s, h, d, sh);
    nb = e[0] ? BEATS : 0;
`ifdef ACE_SNOOP_WRAP_EN
    st = int'((addr / (DW / 8)) % BEATS);
`else
    st = 0;
`endif
    issue_ac(addr, s);
    grant(gd);
    repeat (vd) begin
      chk("cr_wait", cr_valid_o, 0);
      @(negedge clk);
    end
    lkp_valid_i = 1; lkp_hit_i = h; lkp_dirty_i = d; lkp_shared_i = sh; lkp_data_i = line;
    @(negedge clk);
    lkp_valid_i = 0; lkp_data_i = {4{$urandom}};
    chk("upd_first", upd_valid_o, |e[7:5]);
    cr_done = 0; beats = 0; upd_n = 0; n = 0;
    while (!(cr_done && beats == nb) && n < 200) begin
      chk("busy_no_ready", ac_ready_o, 0);
      if (upd_valid_o) begin
        upd_n++;
        chk("upd_flags", {upd_invalidate_o, upd_make_shared_o, upd_clean_o}, e[7:5]);
        chk("upd_addr", upd_addr_o, addr);
      end
      chk("cr_valid", cr_valid_o, !cr_done);
      if (cr_valid_o) chk("cr_resp", cr_resp_o, e[4:0]);
      chk("cd_valid", cd_valid_o, beats < nb);
      if (cd_valid_o && beats < nb) begin
        idx = (st + beats) % BEATS;
        chk("cd_data", cd_data_o, line[idx*DW +: DW]);
        chk("cd_last", cd_last_o, beats == nb - 1);
      end
      cr_ready_i = cr_mode == 1 ? n >= 5 : cr_mode == 2 ? 1'b1 : 1'($urandom);
      cd_ready_i = cd_mode == 1 ? n[0] : cd_mode == 2 ? 1'b1 : 1'($urandom);
      lkp_valid_i = 1'($urandom); lkp_hit_i = 1'($urandom); lkp_data_i = {4{$urandom}};
      if (cr_valid_o && cr_ready_i) cr_done = 1;
      if (cd_valid_o && cd_ready_i) beats++;
      @(negedge clk);
      n++;
    end
    cr_ready_i = 0; cd_ready_i = 0; lkp_valid_i = 0;
    chk("send_timeout", n < 200, 1);
    chk("ac_ready_back", ac_ready_o, 1);
    chk("idle_cr_valid", cr_valid_o, 0);
    chk("idle_cd_valid", cd_valid_o, 0);
    chk("upd_count", upd_n, |e[7:5]);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ac_ready", ac_ready_o, 0);
    chk("rst_outs", {cr_valid_o, cd_valid_o, cd_last_o, lkp_req_o, upd_valid_o}, 0);
    chk("rst_payload", {cr_resp_o, cd_data_o, lkp_addr_o, upd_addr_o}, 0);
    rst_i = 0;
    @(negedge clk);
    run_snoop(64'h1000, 4'b0001, 1, 1, 0, {{4{16'hBBBB}}, {4{16'hAAAA}}}, 2, 2, 0, 0);
    run_snoop(64'h2040, 4'b0111, 0, 1, 0, {4{$urandom}}, 0, 2, 1, 1);
    run_snoop(64'h3000, 4'b0101, 1, 1, 1, {4{$urandom}}, 2, 2, 0, 0);
    run_snoop(64'h4008, 4'b0000, 1, 0, 1, {{4{16'h1111}}, {4{16'h0000}}}, 2, 2, 0, 0);
    run_snoop(64'h5008, 4'b1001, 1, 1, 0, {4{$urandom}}, 1, 2, 0, 0);
    run_snoop(64'h6000, 4'b0111, 1, 0, 0, {4{$urandom}}, 2, 1, 2, 2);
    run_snoop(64'h7000, 4'b1101, 1, 1, 0, {4{$urandom}}, 0, 0, 0, 1);
    run_snoop(64'h8000, 4'b1000, 1, 0, 1, {4{$urandom}}, 0, 0, 1, 0);
    issue_ac(64'h9000, 4'b0001);
    grant(0);
    rst_i = 1;
    @(negedge clk);
    chk("midrst_outs", {ac_ready_o, cr_valid_o, cd_valid_o, cd_last_o, lkp_req_o, upd_valid_o}, 0);
    rst_i = 0; lkp_valid_i = 1; lkp_hit_i = 1; lkp_dirty_i = 1; lkp_data_i = {4{$urandom}};
    @(negedge clk);
    lkp_valid_i = 0;
    chk("late_result_ignored", {cr_valid_o, cd_valid_o, upd_valid_o, lkp_req_o}, 0);
    chk("midrst_ready", ac_ready_o, 1);
    run_snoop(64'hA018, 4'b0010, 1, 1, 1, {4{$urandom}}, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      run_snoop({$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                {4{$urandom}}, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
